simon_key_expand: RTL and testbench

Key-expansion stage for the SIMON 32/64 core. Sits directly upstream of the SIMON round datapath and its controller. It accepts a 64-bit master key on the `newKey` request and generates all T round keys sequentially, one per cycle, into an internal buffer. It then serves round keys to the datapath through a registered read port, so any number of data blocks can be encrypted without re-expanding the key.

---
 rtl/simon_pkg.sv | 23 ++
 rtl/simon_key_round.sv | 22 ++
 rtl/simon_key_expand.sv | 91 +++++++++
 tb/tb_simon_key_expand.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared parameters, constants and types for the SIMON 32/64 key expansion.
package simon_pkg;

  localparam int N = 16;  // word width
  localparam int M = 4;   // master key words
  localparam int T = 32;  // rounds / round keys
  localparam int C = 5;   // round-index width

  // z sequence; z_0 is the leftmost (most significant) bit
  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  // ~k ^ 3 folded into one constant: k ^ 16'hFFFC
  localparam logic [N-1:0] ROUND_CONST = 16'hFFFC;

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  // N-bit rotate right by a fixed amount
  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

endpackage

// File: rtl/simon_key_round.sv
// One combinational key-schedule step: (k[i], k[i+1], k[i+3], z_i) -> k[i+4].
module simon_key_round
  import simon_pkg::*;
(
  input  logic [N-1:0] k_i,
  input  logic [N-1:0] k_i1,
  input  logic [N-1:0] k_i3,
  input  logic         z_bit,
  output logic [N-1:0] k_next
);

  logic [N-1:0] mix_a;
  logic [N-1:0] mix_b;

  // Rotate/xor mixing of the newest words, then fold in the oldest word and constants
  always_comb begin
    mix_a  = ror(k_i3, 3) ^ k_i1;
    mix_b  = mix_a ^ ror(mix_a, 1);
    k_next = k_i ^ ROUND_CONST ^ mix_b ^ {{(N-1){1'b0}}, z_bit};
  end

endmodule

// File: rtl/simon_key_expand.sv
// SIMON 32/64 key expansion: captures a master key, generates all round keys
// one per cycle into a buffer, then serves them through a registered read port.
module simon_key_expand
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                R,
  input  logic                newKey,
  input  logic [M-1:0][N-1:0] key,
  output logic                ldKey,
  output logic                doneKey,
  input  logic [C-1:0]        rdAddr,
  output logic [N-1:0]        rdKey
);

  localparam logic [C-1:0] LAST_IDX = C'(T - M - 1);

  state_t       state;
  logic [C-1:0] round_idx;
  logic [61:0]  z_reg;
  logic [N-1:0] key_buf [T];
  logic [N-1:0] next_word;
  logic [C-1:0] idx_plus1;
  logic [C-1:0] idx_plus3;
  logic [C-1:0] wr_idx;
  logic         load_req;

  assign idx_plus1 = round_idx + C'(1);
  assign idx_plus3 = round_idx + C'(3);
  assign wr_idx    = round_idx + C'(M);
  assign load_req  = newKey && (state == IDLE || state == READY);

  simon_key_round u_round (
    .k_i    (key_buf[round_idx]),
    .k_i1   (key_buf[idx_plus1]),
    .k_i3   (key_buf[idx_plus3]),
    .z_bit  (z_reg[61]),
    .k_next (next_word)
  );

  // Control FSM: load request handling, round counter, z rotation, status flags
  always_ff @(posedge clk) begin
    if (R) begin
      state     <= IDLE;
      round_idx <= '0;
      z_reg     <= Z0;
      ldKey     <= 1'b0;
      doneKey   <= 1'b0;
    end else begin
      ldKey <= 1'b0;
      case (state)
        IDLE, READY: begin
          if (newKey) begin
            round_idx <= '0;
            z_reg     <= Z0;
            ldKey     <= 1'b1;
            doneKey   <= 1'b0;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          z_reg     <= {z_reg[60:0], z_reg[61]};
          round_idx <= round_idx + C'(1);
          if (round_idx == LAST_IDX) begin
            doneKey <= 1'b1;
            state   <= READY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Key buffer: master words on load, one expanded word per EXPAND cycle; never cleared
  always_ff @(posedge clk) begin
    if (!R) begin
      if (load_req) begin
        for (int j = 0; j < M; j++) key_buf[j] <= key[j];
      end else if (state == EXPAND) begin
        key_buf[wr_idx] <= next_word;
      end
    end
  end

  // Registered read port, active in every state
  always_ff @(posedge clk) begin
    if (R) rdKey <= '0;
    else   rdKey <= key_buf[rdAddr];
  end

endmodule

// File: tb/tb_simon_key_expand.sv
// Self-checking bench for simon_key_expand: load timing, full schedules
// against an independent software model, ignored loads, reload and reset cases.
module tb_simon_key_expand;

  logic             clk = 1'b0;
  logic             R;
  logic             newKey;
  logic [3:0][15:0] key;
  logic             ldKey;
  logic             doneKey;
  logic [4:0]       rdAddr;
  logic [15:0]      rdKey;

  int checks = 0;
  int fails  = 0;

  logic [15:0] gold [32];
  logic [15:0] expQ [$];

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [5];

  localparam logic [63:0] KEY_A = 64'h1918_1110_0908_0100;
  localparam logic [63:0] KEY_B = 64'h0123_4567_89AB_CDEF;

  simon_key_expand dut (
    .clk     (clk),
    .R       (R),
    .newKey  (newKey),
    .key     (key),
    .ldKey   (ldKey),
    .doneKey (doneKey),
    .rdAddr  (rdAddr),
    .rdKey   (rdKey)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard stop in case the run never reaches its summary
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference schedule using an indexed z bit instead of a rotating register
  task automatic computeGold(input logic [63:0] mk);
    logic [61:0] zc;
    logic [15:0] t;
    int          j;
    zc = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) gold[i] = mk[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = {gold[i-1][2:0], gold[i-1][15:3]} ^ gold[i-3];
      t = t ^ {t[0], t[15:1]};
      j = (i - 4) % 62;
      gold[i] = ~gold[i-4] ^ t ^ {15'b0, zc[61-j]} ^ 16'h0003;
    end
  endtask

  // Request a load and check the capture-edge response
  task automatic applyStimulus(input string name, input logic [63:0] mk);
    key    = mk;
    newKey = 1'b1;
    tick();
    newKey = 1'b0;
    checkOutput({name, " ldKey pulse"}, {15'b0, ldKey}, 16'd1);
    checkOutput({name, " doneKey low on load"}, {15'b0, doneKey}, 16'd0);
  endtask

  // Count edges after the load edge until doneKey rises
  task automatic waitDone(input string name);
    int cnt;
    cnt = 0;
    while (cnt < 40) begin
      cnt++;
      tick();
      if (cnt == 1) checkOutput({name, " ldKey single cycle"}, {15'b0, ldKey}, 16'd0);
      if (doneKey) break;
    end
    if (!doneKey) cnt = 41;
    checkOutput({name, " doneKey latency"}, 16'(cnt), 16'd28);
  endtask

  // Read every round key through the scoreboard and compare against the model
  task automatic readSchedule(input string name);
    for (int a = 0; a < 32; a++) begin
      rdAddr = 5'(a);
      expQ.push_back(gold[a]);
      tick();
      checkOutput($sformatf("%s k[%0d]", name, a), rdKey, expQ.pop_front());
    end
  endtask

  initial begin
    int cnt;

    vecs[0] = '{5'd0, 16'h0100};
    vecs[1] = '{5'd1, 16'h0908};
    vecs[2] = '{5'd2, 16'h1110};
    vecs[3] = '{5'd3, 16'h1918};
    vecs[4] = '{5'd4, 16'h71C3};

    R      = 1'b1;
    newKey = 1'b0;
    key    = '0;
    rdAddr = '0;
    tick();
    tick();
    checkOutput("reset ldKey", {15'b0, ldKey}, 16'd0);
    checkOutput("reset doneKey", {15'b0, doneKey}, 16'd0);
    checkOutput("reset rdKey", rdKey, 16'h0000);
    R = 1'b0;
    tick();

    $display("[TB] basic load of the reference key");
    applyStimulus("loadA", KEY_A);
    waitDone("loadA");
    for (int v = 0; v < 5; v++) begin
      rdAddr = vecs[v].addr;
      expQ.push_back(vecs[v].exp);
      tick();
      checkOutput($sformatf("vector %0d", v), rdKey, expQ.pop_front());
    end
    computeGold(KEY_A);
    readSchedule("schedA");

    $display("[TB] back-to-back load with newKey held");
    key    = KEY_A;
    newKey = 1'b1;
    tick();
    checkOutput("b2b first ldKey", {15'b0, ldKey}, 16'd1);
    cnt = 0;
    while (cnt < 40) begin
      cnt++;
      tick();
      if (doneKey) break;
    end
    if (!doneKey) cnt = 41;
    checkOutput("b2b first latency", 16'(cnt), 16'd28);
    tick();
    newKey = 1'b0;
    checkOutput("b2b second ldKey", {15'b0, ldKey}, 16'd1);
    checkOutput("b2b doneKey dropped", {15'b0, doneKey}, 16'd0);
    waitDone("b2b second");
    readSchedule("schedA2");

    $display("[TB] newKey during expansion is ignored");
    applyStimulus("ignore", KEY_A);
    cnt = 0;
    while (cnt < 40) begin
      cnt++;
      if (cnt == 10) begin
        key    = KEY_B;
        newKey = 1'b1;
      end
      tick();
      if (cnt == 10) begin
        newKey = 1'b0;
        checkOutput("ignore no ldKey", {15'b0, ldKey}, 16'd0);
      end
      if (doneKey) break;
    end
    if (!doneKey) cnt = 41;
    checkOutput("ignore latency", 16'(cnt), 16'd28);
    readSchedule("schedIgnore");

    $display("[TB] reload in READY with a different key");
    applyStimulus("loadB", KEY_B);
    waitDone("loadB");
    computeGold(KEY_B);
    readSchedule("schedB");

    $display("[TB] reset in the middle of expansion");
    applyStimulus("abort", KEY_A);
    for (int c = 0; c < 14; c++) tick();
    R = 1'b1;
    tick();
    R = 1'b0;
    checkOutput("abort doneKey", {15'b0, doneKey}, 16'd0);
    checkOutput("abort ldKey", {15'b0, ldKey}, 16'd0);
    checkOutput("abort rdKey", rdKey, 16'h0000);
    for (int c = 0; c < 35; c++) tick();
    checkOutput("abort stays idle", {15'b0, doneKey}, 16'd0);
    applyStimulus("reloadA", KEY_A);
    waitDone("reloadA");
    computeGold(KEY_A);
    readSchedule("schedA3");

    $display("[TB] reset and newKey together");
    key    = KEY_B;
    R      = 1'b1;
    newKey = 1'b1;
    tick();
    R      = 1'b0;
    newKey = 1'b0;
    checkOutput("priority ldKey", {15'b0, ldKey}, 16'd0);
    checkOutput("priority doneKey", {15'b0, doneKey}, 16'd0);
    for (int c = 0; c < 35; c++) tick();
    checkOutput("priority stays idle", {15'b0, doneKey}, 16'd0);
    checkOutput("priority no ldKey", {15'b0, ldKey}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
